bakraid_snd_mailbox: RTL
========================

Name: bakraid_snd_mailbox

Overview:
- 68000-side end of the main-CPU/sound-CPU mailbox. The sound block is the Z80 end.
- Decodes 68k accesses to the sound register window and drives SOUNDLATCH and SOUNDLATCH2 toward the Z80.
- Generates the NMI and CS edges that wake the Z80 and arm its WAIT flip-flop. Returns SOUNDLATCH3/4 to the 68k, stalling DTACK while the Z80 reply is pending.
- Latches the sound IRQ as an acknowledgeable interrupt request for the 68k.

Parameters:
- NMI_W, 4, width in CLK96 cycles of the NMI_OUT/CS_OUT pulses.
- TMO, 9600, read-stall timeout in CLK96 cycles (100 us).
- TW, 14, timeout counter width; must satisfy 2^TW > TMO.

Ports:
- CLK96 in 1 system clock, 96 MHz.
- RESET96 in 1 reset, asynchronous, active-high.
- M68K_CS in 1 level-high select of the sound register window.
- M68K_ADDR in 2 word offset, A[2:1].
- M68K_RNW in 1 1 = read, 0 = write.
- M68K_UDSN in 1 upper data strobe, active-low.
- M68K_LDSN in 1 lower data strobe, active-low.
- M68K_DIN in 16 write data.
- M68K_DOUT out 16 read data.
- M68K_DTACKN out 1 data acknowledge, active-low.
- SOUNDLATCH out 8 command byte to the Z80.
- SOUNDLATCH2 out 8 second command byte to the Z80.
- NMI_OUT out 1 rising edge triggers the Z80 NMI.
- CS_OUT out 1 rising edge arms the sound-side WAIT.
- WAIT in 1 high = Z80 reply not yet written.
- SOUNDLATCH3 in 8 Z80 reply byte.
- SOUNDLATCH4 in 8 Z80 reply byte.
- SNDIRQ in 1 sound interrupt, level from the Z80 side.
- IRQ_OUT out 1 pending interrupt request to the 68k.

Behaviour:
- Reset values:
  - DOUT = 0, DTACKN = 1.
  - SOUNDLATCH and SOUNDLATCH2 = 0.
  - NMI_OUT = 0, CS_OUT = 0, IRQ_OUT = 0.
  - Timeout flag = 0, FSM = IDLE.
- An access starts on the first CLK96 edge where CS = 1 and either strobe is low while in IDLE. It is decoded once; ADDR, RNW, DIN and the strobes are captured at that edge.
- Write map (ADDR):
  - 0: SOUNDLATCH <= DIN[7:0].
  - 1: SOUNDLATCH2 <= DIN[7:0].
  - 2: NMI trigger; data ignored.
  - 3: IRQ acknowledge; clears IRQ_OUT.
- Latch writes occur only if LDSN = 0. A UDS-only write is acknowledged with no side effect.
- Read map (ADDR):
  - 0: {8'h00, SOUNDLATCH3}.
  - 1: {8'h00, SOUNDLATCH4}.
  - 2: status {13'b0, timeout_flag, WAIT, IRQ_OUT}.
  - 3: 16'h0000.
- FSM states: IDLE, WR_ACK, RD_WAIT, RD_ACK, HOLD.
  - IDLE -> WR_ACK on a write; the register effect is applied in that same edge.
  - IDLE -> RD_WAIT on a read of ADDR 0/1 while WAIT = 1.
  - IDLE -> RD_ACK on all other reads.
  - RD_WAIT -> RD_ACK when WAIT = 0 (timeout_flag cleared) or when the counter reaches TMO-1 (timeout_flag set). The counter is cleared on entry.
  - WR_ACK/RD_ACK: DTACKN = 0 and DOUT valid. For reads, DOUT is sampled on entry to RD_ACK. Then -> HOLD.
  - HOLD: DTACKN stays 0 until CS = 0 or both strobes are high, then DTACKN = 1 and -> IDLE. No second decode occurs within one bus cycle.
- Latency:
  - Writes: DTACKN low 1 cycle after decode.
  - Non-stalled reads: DTACKN low 1 cycle after decode.
  - Stalled reads: DTACKN low 1 cycle after WAIT falls.
- NMI trigger write:
  - NMI_OUT and CS_OUT go high together for NMI_W cycles, then low.
  - A retrigger during an active pulse restarts the count with no low gap. The pulse is not re-edged.
- IRQ:
  - IRQ_OUT sets on the rising edge of SNDIRQ, detected with a registered copy of SNDIRQ.
  - An ack write clears IRQ_OUT. If a rising edge and an ack occur in the same cycle, set wins.
- Reset mid-access: all state is cleared asynchronously. A bus cycle in progress is abandoned; the CPU reset covers it.

Decomposition:
- Shared package bakraid_pkg holds:
  - Register offset constants: SND_LATCH, SND_LATCH2, SND_NMI, SND_IRQACK, SND_RPLY3, SND_RPLY4, SND_STAT.
  - The FSM state enumeration.
  - Status bit indices.
- One sub-module, bakraid_pulse_stretch: retriggerable NMI_W-cycle pulse generator used for NMI_OUT/CS_OUT.

Test Plan:
- Write 16'h12A5 at ADDR 0 with LDSN = 0 -> SOUNDLATCH = 8'hA5 next cycle; DTACKN low 1 cycle after decode; UDS-only write leaves SOUNDLATCH at 8'hA5.
- Write ADDR 2 -> NMI_OUT and CS_OUT high for exactly 4 cycles; a second write at pulse cycle 2 extends the high time to 2 + 4 cycles with a single rising edge.
- Read ADDR 0 with WAIT = 1, SOUNDLATCH3 = 8'h3C; drop WAIT after 50 cycles -> DTACKN low at cycle 51, DOUT = 16'h003C, status bit2 = 0.
- Read ADDR 1 with WAIT held high -> DTACKN low after 9600 cycles; status read = 16'h0006 (timeout = 1, WAIT = 1, IRQ = 0).
- SNDIRQ rising edge -> IRQ_OUT = 1; an ack write in the same cycle as another rising edge leaves IRQ_OUT = 1; a lone ack clears it.
- Assert RESET96 during RD_WAIT -> DTACKN = 1, latches = 0, FSM = IDLE immediately (asynchronous); the next access decodes normally.

Source files
------------

// File: rtl/bakraid_pkg.sv
// bakraid_pkg: register offsets, status bit positions and FSM states shared by the 68k-side sound mailbox.
package bakraid_pkg;
  localparam logic [1:0] SND_LATCH  = 2'd0;
  localparam logic [1:0] SND_LATCH2 = 2'd1;
  localparam logic [1:0] SND_NMI    = 2'd2;
  localparam logic [1:0] SND_IRQACK = 2'd3;
  localparam logic [1:0] SND_RPLY3  = 2'd0;
  localparam logic [1:0] SND_RPLY4  = 2'd1;
  localparam logic [1:0] SND_STAT   = 2'd2;
  localparam int ST_IRQ  = 0;
  localparam int ST_WAIT = 1;
  localparam int ST_TMO  = 2;
  typedef enum logic [2:0] {IDLE, WR_ACK, RD_WAIT, RD_ACK, HOLD} snd_state_t;
endpackage

// File: rtl/bakraid_pulse_stretch.sv
// bakraid_pulse_stretch: retriggerable W-cycle pulse; a trigger while high reloads the count without a low gap.
module bakraid_pulse_stretch #(
  parameter int W = 4
) (
  input  logic CLK96,
  input  logic RESET96,
  input  logic trig,
  output logic pulse
);
  localparam int CW = $clog2(W + 1);
  logic [CW-1:0] cnt;
  always_ff @(posedge CLK96 or posedge RESET96)
    if (RESET96) cnt <= '0;
    else if (trig) cnt <= CW'(W);
    else if (cnt != '0) cnt <= cnt - CW'(1);
  assign pulse = cnt != '0;
endmodule

// File: rtl/bakraid_snd_mailbox.sv
// bakraid_snd_mailbox: 68k end of the sound mailbox; latches commands to the Z80, stalls reads until the Z80 replies.
module bakraid_snd_mailbox
  import bakraid_pkg::*;
#(
  parameter int NMI_W = 4,
  parameter int TMO   = 9600,
  parameter int TW    = 14
) (
  input  logic        CLK96,
  input  logic        RESET96,
  input  logic        M68K_CS,
  input  logic [1:0]  M68K_ADDR,
  input  logic        M68K_RNW,
  input  logic        M68K_UDSN,
  input  logic        M68K_LDSN,
  input  logic [15:0] M68K_DIN,
  output logic [15:0] M68K_DOUT,
  output logic        M68K_DTACKN,
  output logic [7:0]  SOUNDLATCH,
  output logic [7:0]  SOUNDLATCH2,
  output logic        NMI_OUT,
  output logic        CS_OUT,
  input  logic        WAIT,
  input  logic [7:0]  SOUNDLATCH3,
  input  logic [7:0]  SOUNDLATCH4,
  input  logic        SNDIRQ,
  output logic        IRQ_OUT
);
  snd_state_t state, nxt;
  logic [1:0] addr_q, rd_addr;
  logic [TW-1:0] cnt;
  logic [15:0] status, rd_data;
  logic tmo_flag, sndirq_q, start, wr, rd_stall, nmi_trig, irq_ack, irq_rise, pulse;
  logic unused_din;
  assign unused_din = &{1'b0, M68K_DIN[15:8]};
  assign start = state == IDLE && M68K_CS && !(M68K_UDSN && M68K_LDSN);
  // UDS-only writes are acknowledged but have no side effect at all
  assign wr = start && !M68K_RNW && !M68K_LDSN;
  assign nmi_trig = wr && M68K_ADDR == SND_NMI;
  assign irq_ack = wr && M68K_ADDR == SND_IRQACK;
  assign irq_rise = SNDIRQ && !sndirq_q;
  assign rd_stall = WAIT && (M68K_ADDR == SND_RPLY3 || M68K_ADDR == SND_RPLY4);
  assign rd_addr = state == IDLE ? M68K_ADDR : addr_q;
  assign M68K_DTACKN = !(state == WR_ACK || state == RD_ACK || state == HOLD);
  always_comb begin
    status = '0;
    status[ST_IRQ] = IRQ_OUT;
    status[ST_WAIT] = WAIT;
    status[ST_TMO] = tmo_flag;
    rd_data = rd_addr == SND_RPLY3 ? {8'h00, SOUNDLATCH3} :
              rd_addr == SND_RPLY4 ? {8'h00, SOUNDLATCH4} :
              rd_addr == SND_STAT  ? status : 16'h0000;
  end
  always_comb begin
    nxt = state;
    case (state)
      IDLE:           if (start) nxt = M68K_RNW ? (rd_stall ? RD_WAIT : RD_ACK) : WR_ACK;
      RD_WAIT:        if (!WAIT || cnt == TW'(TMO - 1)) nxt = RD_ACK;
      WR_ACK, RD_ACK: nxt = HOLD;
      HOLD:           if (!M68K_CS || (M68K_UDSN && M68K_LDSN)) nxt = IDLE;
      default:        nxt = IDLE;
    endcase
  end
  always_ff @(posedge CLK96 or posedge RESET96)
    if (RESET96) begin
      state <= IDLE;
      addr_q <= '0;
      cnt <= '0;
      tmo_flag <= 1'b0;
      sndirq_q <= 1'b0;
      M68K_DOUT <= '0;
      SOUNDLATCH <= '0;
      SOUNDLATCH2 <= '0;
      IRQ_OUT <= 1'b0;
    end else begin
      state <= nxt;
      sndirq_q <= SNDIRQ;
      cnt <= state == RD_WAIT ? cnt + TW'(1) : '0;
      if (start) addr_q <= M68K_ADDR;
      // WAIT still high on leaving the stall means the counter expired
      if (state == RD_WAIT && nxt == RD_ACK) tmo_flag <= WAIT;
      if (nxt == RD_ACK) M68K_DOUT <= rd_data;
      if (wr && M68K_ADDR == SND_LATCH) SOUNDLATCH <= M68K_DIN[7:0];
      if (wr && M68K_ADDR == SND_LATCH2) SOUNDLATCH2 <= M68K_DIN[7:0];
      IRQ_OUT <= irq_rise || (IRQ_OUT && !irq_ack);
    end
  bakraid_pulse_stretch #(.W(NMI_W)) u_nmi (
    .CLK96(CLK96),
    .RESET96(RESET96),
    .trig(nmi_trig),
    .pulse(pulse)
  );
  assign NMI_OUT = pulse;
  assign CS_OUT = pulse;
endmodule
